// File: rtl/io_mmio_pkg.sv
// io_mmio_pkg: I/O-window select bits, read-priority decode and debounce counter sizing
// shared by io_mmio and io_debounce.
package io_mmio_pkg;

    localparam int unsigned IO_IS_BIT   = 8;
    localparam int unsigned IO_LEDS_BIT = 2;
    localparam int unsigned IO_HEX_BIT  = 3;
    localparam int unsigned IO_KEY_BIT  = 4;
    localparam int unsigned IO_SW_BIT   = 5;
    localparam int unsigned IO_EDGE_BIT = 6;
    localparam int unsigned IO_MASK_BIT = 7;

    typedef enum logic [2:0] {
        RdNone,
        RdLeds,
        RdHex,
        RdKey,
        RdSw,
        RdEdge,
        RdMask
    } io_rd_e;

    // Several select bits may be set at once; the lowest address bit wins.
    function automatic io_rd_e io_read_sel(input logic [31:0] addr);
        io_rd_e sel;
        sel = RdNone;
        if (addr[IO_IS_BIT]) begin
            if (addr[IO_LEDS_BIT])      sel = RdLeds;
            else if (addr[IO_HEX_BIT])  sel = RdHex;
            else if (addr[IO_KEY_BIT])  sel = RdKey;
            else if (addr[IO_SW_BIT])   sel = RdSw;
            else if (addr[IO_EDGE_BIT]) sel = RdEdge;
            else if (addr[IO_MASK_BIT]) sel = RdMask;
        end
        return sel;
    endfunction

    function automatic int unsigned io_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/dec7seg.sv
// dec7seg: hex digit to active-low 7-segment pattern, seg[6:0] = {g,f,e,d,c,b,a}.
module dec7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/io_debounce.sv
// io_debounce: per-bit 2-flop synchroniser followed by a stability counter; an input is
// accepted once it has differed from the stable value for DEBOUNCE_CYCLES consecutive cycles.
module io_debounce
    import io_mmio_pkg::*;
#(
    parameter int unsigned    WIDTH           = 4,
    parameter int unsigned    DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable
);

    localparam int unsigned      CNT_W   = io_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_mmio.sv
// io_mmio: memory-mapped LED/HEX/KEY/SW controller for the CPU I/O window (addr[8] set).
// Define IO_MMIO_IRQ_EN to build the interrupt mask register and the irq output.
module io_mmio
    import io_mmio_pkg::*;
#(
    parameter int unsigned NUM_LEDS        = 10,
    parameter int unsigned NUM_HEX         = 6,
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SW          = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr,
    input  logic [31:0]           writedata,
    input  logic                  memwrite,
    output logic [31:0]           rdata,
    input  logic [NUM_KEYS-1:0]   key_in,
    input  logic [NUM_SW-1:0]     sw_in,
    output logic [NUM_LEDS-1:0]   ledr,
    output logic [7*NUM_HEX-1:0]  hex_seg,
    output logic                  irq
);

    logic                   wr_en;
    logic [NUM_LEDS-1:0]    led_q;
    logic [4*NUM_HEX-1:0]   hex_q;
    logic [NUM_KEYS-1:0]    key_stable, key_level, key_prev_q;
    logic [NUM_KEYS-1:0]    edge_q, edge_d, edge_clr, mask_rd;
    logic [NUM_SW-1:0]      sw_stable;
    logic                   unused_bits;

    assign wr_en       = memwrite & addr[IO_IS_BIT];
    assign unused_bits = ^{addr, writedata};

    io_debounce #(
        .WIDTH           (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       ({NUM_KEYS{1'b1}})
    ) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .din    (key_in),
        .stable (key_stable)
    );

    io_debounce #(
        .WIDTH           (NUM_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       ({NUM_SW{1'b0}})
    ) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .din    (sw_in),
        .stable (sw_stable)
    );

    assign key_level = ~key_stable;

    // A press (stable 1->0) outranks a W1C clear landing in the same cycle.
    assign edge_clr = (wr_en && addr[IO_EDGE_BIT]) ? writedata[NUM_KEYS-1:0] : '0;
    assign edge_d   = (edge_q & ~edge_clr) | (key_prev_q & ~key_stable);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q      <= '0;
            hex_q      <= '0;
            key_prev_q <= '1;
            edge_q     <= '0;
        end else begin
            if (wr_en && addr[IO_LEDS_BIT]) led_q <= writedata[NUM_LEDS-1:0];
            if (wr_en && addr[IO_HEX_BIT])  hex_q <= writedata[4*NUM_HEX-1:0];
            key_prev_q <= key_stable;
            edge_q     <= edge_d;
        end
    end

`ifdef IO_MMIO_IRQ_EN
    logic [NUM_KEYS-1:0] mask_q;
    logic                irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && addr[IO_MASK_BIT]) mask_q <= writedata[NUM_KEYS-1:0];
            irq_q <= |(edge_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (io_read_sel(addr))
            RdLeds:  rdata = 32'(led_q);
            RdHex:   rdata = 32'(hex_q);
            RdKey:   rdata = 32'(key_level);
            RdSw:    rdata = 32'(sw_stable);
            RdEdge:  rdata = 32'(edge_q);
            RdMask:  rdata = 32'(mask_rd);
            default: rdata = '0;
        endcase
    end

    assign ledr = led_q;

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        dec7seg u_dec7seg (
            .hex (hex_q[4*i +: 4]),
            .seg (hex_seg[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_io_mmio.sv
// tb_io_mmio: vector table, hand-written debounce/edge/irq sequences and a randomized run
// checked against a sliding-window behavioural model of io_mmio.
module tb_io_mmio;

    localparam int unsigned DB = 16;

`ifdef IO_MMIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic [31:0] rdata;
    logic [3:0]  key_in = 4'hF;
    logic [9:0]  sw_in = '0;
    logic [9:0]  ledr;
    logic [41:0] hex_seg;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_mmio #(
        .NUM_LEDS        (10),
        .NUM_HEX         (6),
        .NUM_KEYS        (4),
        .NUM_SW          (10),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .rdata     (rdata),
        .key_in    (key_in),
        .sw_in     (sw_in),
        .ledr      (ledr),
        .hex_seg   (hex_seg),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        memwrite = 1'b0;
        #1;
        check(name, rdata, exp);
    endtask

    // Write during one cycle, then drop the strobe at the next negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        addr = a;
        writedata = wd;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input logic [23:0] h);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_of(h[4*i +: 4]);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [9:0]  m_led;
    logic [23:0] m_hex;
    logic [3:0]  m_edge, m_mask, k_stable, k_prev;
    logic [9:0]  s_stable;
    logic        m_irq;
    logic [3:0]  k_hist[$];   // [0] = newest pin sample
    logic [9:0]  s_hist[$];

    task automatic model_reset();
        m_led = '0; m_hex = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
        k_stable = 4'hF; k_prev = 4'hF; s_stable = '0;
        k_hist.delete();
        s_hist.delete();
        for (int i = 0; i < DB + 2; i++) begin
            k_hist.push_back(4'hF);
            s_hist.push_back(10'h0);
        end
    endtask

    // A bit flips when its synchronised value differed from stable over the last DB cycles.
    function automatic logic [3:0] key_next();
        logic [3:0] r;
        bit all_diff;
        r = k_stable;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) if (k_hist[j][b] == k_stable[b]) all_diff = 1'b0;
            if (all_diff) r[b] = ~k_stable[b];
        end
        return r;
    endfunction

    function automatic logic [9:0] sw_next();
        logic [9:0] r;
        bit all_diff;
        r = s_stable;
        for (int b = 0; b < 10; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) if (s_hist[j][b] == s_stable[b]) all_diff = 1'b0;
            if (all_diff) r[b] = ~s_stable[b];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!a[8])      return 32'h0;
        if (a[2])       return {22'h0, m_led};
        else if (a[3])  return {8'h0, m_hex};
        else if (a[4])  return {28'h0, ~k_stable};
        else if (a[5])  return {22'h0, s_stable};
        else if (a[6])  return {28'h0, m_edge};
        else if (a[7])  return {28'h0, m_mask};
        return 32'h0;
    endfunction

    task automatic model_clock();
        logic       wr;
        logic [3:0] clr, kn;
        logic [9:0] sn;
        wr  = memwrite && addr[8];
        clr = (wr && addr[6]) ? writedata[3:0] : 4'h0;
        kn  = key_next();
        sn  = sw_next();
        m_irq  = IRQ_EN && ((m_edge & m_mask) != 4'h0);
        m_edge = (m_edge & ~clr) | (k_prev & ~k_stable);
        k_prev   = k_stable;
        k_stable = kn;
        s_stable = sn;
        k_hist.push_front(key_in);
        void'(k_hist.pop_back());
        s_hist.push_front(sw_in);
        void'(s_hist.pop_back());
        if (wr && addr[2]) m_led = writedata[9:0];
        if (wr && addr[3]) m_hex = writedata[23:0];
        if (IRQ_EN && wr && addr[7]) m_mask = writedata[3:0];
    endtask

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1000000;
        $display("FAIL timeout: bench still running, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int idx;

        vt[0]  = '{32'h104, 1'b1, 32'h0000_02A5, 32'h2A5};
        vt[1]  = '{32'h108, 1'b1, 32'h0012_3456, 32'h123456};
        vt[2]  = '{32'h104, 1'b0, 32'h0000_0000, 32'h2A5};
        vt[3]  = '{32'h10C, 1'b1, 32'hFFFF_FFFF, 32'h3FF};
        vt[4]  = '{32'h108, 1'b0, 32'h0000_0000, 32'hFFFFFF};
        vt[5]  = '{32'h004, 1'b1, 32'h0000_0000, 32'h0};
        vt[6]  = '{32'h104, 1'b0, 32'h0000_0000, 32'h3FF};
        vt[7]  = '{32'h100, 1'b1, 32'h0000_0123, 32'h0};
        vt[8]  = '{32'h180, 1'b1, 32'h0000_0005, IRQ_EN ? 32'h5 : 32'h0};
        vt[9]  = '{32'h1C0, 1'b0, 32'h0000_0000, 32'h0};
        vt[10] = '{32'h130, 1'b0, 32'h0000_0000, 32'h0};
        vt[11] = '{32'h184, 1'b0, 32'h0000_0000, 32'h3FF};

        // Reset state
        reset = 1'b0;
        key_in = 4'hF;
        sw_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ledr", ledr, 0);
        check("rst_irq", irq, 0);
        check("rst_hex", hex_seg, exp_hex(24'h0));
        read_chk("rst_key", 32'h110, 0);
        read_chk("rst_sw", 32'h120, 0);
        read_chk("rst_edge", 32'h140, 0);

        // Register access table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            addr = vt[i].a;
            memwrite = vt[i].we;
            writedata = vt[i].wd;
            @(negedge clk);
            memwrite = 1'b0;
            #1;
            check($sformatf("vec%0d_addr%0h", i, vt[i].a), rdata, vt[i].exp);
        end

        // LED and HEX display
        @(negedge clk);
        addr = 32'h104; writedata = 32'h2A5; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        check("led_next_cycle", ledr, 10'h2A5);
        bus_write(32'h108, 32'h0012_3456);
        #1;
        check("hex_display", hex_seg, exp_hex(24'h123456));
        read_chk("hex_read", 32'h108, 32'h123456);
        bus_write(32'h180, 32'h2);

        // Short glitch on key 1 must not register
        @(negedge clk);
        key_in[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * DB; i++) begin
            @(negedge clk);
            if (i == DB - 3) key_in = 4'hF;
            addr = 32'h110; #1;
            if (rdata != 0) bad++;
            addr = 32'h140; #1;
            if (rdata != 0) bad++;
        end
        check("glitch_ignored", bad, 0);

        // Held press: stable after 2+DB cycles, edge one later, irq one after that
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int i = 1; i <= DB + 1; i++) @(negedge clk);
        read_chk("press_key_early", 32'h110, 0);
        @(negedge clk);
        read_chk("press_key", 32'h110, 32'h2);
        read_chk("press_edge_early", 32'h140, 0);
        @(negedge clk);
        read_chk("press_edge", 32'h140, 32'h2);
        check("irq_early", irq, 0);
        @(negedge clk);
        #1;
        check("irq_set", irq, IRQ_EN);

        // W1C clear: flag drops next cycle, irq one cycle after that
        bus_write(32'h140, 32'h2);
        read_chk("clr_edge", 32'h140, 0);
        check("irq_hold", irq, IRQ_EN);
        @(negedge clk);
        #1;
        check("irq_clr", irq, 0);

        // Release sets no flag
        key_in = 4'hF;
        repeat (DB + 4) @(negedge clk);
        read_chk("release_no_edge", 32'h140, 0);

        // Press landing in the clear cycle keeps the flag set
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int i = 1; i <= DB + 2; i++) @(negedge clk);
        addr = 32'h140; writedata = 32'h2; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        read_chk("set_beats_clr", 32'h140, 32'h2);
        bus_write(32'h140, 32'h0);
        read_chk("w0_noop", 32'h140, 32'h2);
        bus_write(32'h140, 32'hF);
        key_in = 4'hF;

        // Switches: full settle, then toggle every 3 cycles
        @(negedge clk);
        sw_in = 10'h3FF;
        for (int i = 1; i <= DB + 1; i++) @(negedge clk);
        read_chk("sw_early", 32'h120, 0);
        @(negedge clk);
        read_chk("sw_stable", 32'h120, 32'h3FF);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c % 3 == 0) sw_in = ~sw_in;
            addr = 32'h120; #1;
            if (rdata != 32'h3FF) bad++;
        end
        check("sw_toggle_ignored", bad, 0);

        // Reset in the middle of a debounce, then randomized run against the model
        @(negedge clk);
        key_in = 4'h0;
        sw_in = 10'h155;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        memwrite = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n != 0) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, 3);
                key_in[idx] = ~key_in[idx];
            end
            if ($urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, 9);
                sw_in[idx] = ~sw_in[idx];
            end
            case ($urandom_range(0, 9))
                0: addr = 32'h104;
                1: addr = 32'h108;
                2: addr = 32'h110;
                3: addr = 32'h120;
                4: addr = 32'h140;
                5: addr = 32'h180;
                6: addr = 32'h10C;
                7: addr = 32'h1C0;
                8: addr = 32'h130;
                default: addr = $urandom;
            endcase
            memwrite = ($urandom_range(0, 3) == 0);
            writedata = $urandom;
            if (addr[6] && $urandom_range(0, 1) == 0) writedata = 32'h0;
            #1;
            check("rnd_rdata", rdata, model_rd(addr));
            check("rnd_ledr", ledr, m_led);
            check("rnd_hex", hex_seg, exp_hex(m_hex));
            check("rnd_irq", irq, m_irq);
            @(posedge clk);
            model_clock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
